// File: rtl/vc_input_port_credit_if.sv
// Flit/route types plus the handshake bundle between link, allocators and input port.
// Latency: none; wiring and types only.
// Backpressure: credit pulses flow upstream, allocator grants flow in.
package vc_input_port_credit_pkg;
   localparam int MESH_SIZE_X = 4;
   localparam int MESH_SIZE_Y = 4;
   localparam int COORD_W     = 3;
   // vc_id width; must cover every VC the port is built with
   localparam int VC_ID_W     = 1;

   typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} flit_label_t;

   // Y coordinates grow towards SOUTH
   typedef enum logic [2:0] {LOCAL = 3'd0, NORTH = 3'd1, SOUTH = 3'd2, EAST = 3'd3, WEST = 3'd4} port_t;

   typedef struct packed {
      flit_label_t        flit_label;
      logic [VC_ID_W-1:0] vc_id;
      logic [COORD_W-1:0] x_dest;
      logic [COORD_W-1:0] y_dest;
      logic [15:0]        payload;
   } flit_t;
endpackage

interface vc_input_port_credit_if #(parameter int VC_NUM = 2);
   import vc_input_port_credit_pkg::*;

   flit_t                              data_i;
   logic                               valid_flit_i;
   logic  [VC_NUM-1:0]                 credit_o;
   logic  [VC_NUM-1:0]                 va_req_o;
   port_t [VC_NUM-1:0]                 out_port_o;
   logic  [VC_NUM-1:0]                 va_grant_i;
   logic  [VC_NUM-1:0][VC_ID_W-1:0]    vc_new_i;
   logic  [VC_NUM-1:0]                 sa_req_o;
   logic  [VC_NUM-1:0]                 sa_grant_i;
   flit_t                              flit_o;
   logic                               flit_valid_o;
   logic                               error_o;

   // Input port side
   modport master (
      input  data_i, valid_flit_i, va_grant_i, vc_new_i, sa_grant_i,
      output credit_o, va_req_o, out_port_o, sa_req_o, flit_o, flit_valid_o, error_o
   );

   // Link receiver / allocator side
   modport slave (
      output data_i, valid_flit_i, va_grant_i, vc_new_i, sa_grant_i,
      input  credit_o, va_req_o, out_port_o, sa_req_o, flit_o, flit_valid_o, error_o
   );
endinterface

// File: rtl/vc_input_port_credit.sv
// Router input port: per-VC circular flit buffers, IDLE/VA/ACTIVE packet FSM, XY routing, credit return.
// Latency: write visible to FSM next cycle; departing flit and credit pulse 1 cycle after switch grant.
// Backpressure: upstream throttled by one credit per flit read; writes to a full VC are dropped and flagged.
module vc_input_port_credit
   import vc_input_port_credit_pkg::*;
#(
   parameter int VC_NUM      = 2,
   parameter int BUFFER_SIZE = 8,
   parameter int X_CURRENT   = MESH_SIZE_X / 2,
   parameter int Y_CURRENT   = MESH_SIZE_Y / 2
) (
   input  logic                    clk,
   input  logic                    rst,
   vc_input_port_credit_if.master  port_if
);

   localparam int PTR_W = $clog2(BUFFER_SIZE);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, VA = 2'd1, ACTIVE = 2'd2} vc_state_t;

   flit_t                           buf_q [VC_NUM][BUFFER_SIZE];
   logic  [VC_NUM-1:0][PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic  [VC_NUM-1:0][PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic  [VC_NUM-1:0][CNT_W-1:0]   cnt_q, cnt_d;
   vc_state_t                       state_q [VC_NUM];
   vc_state_t                       state_d [VC_NUM];
   port_t [VC_NUM-1:0]              out_port_q, out_port_d;
   logic  [VC_NUM-1:0][VC_ID_W-1:0] vc_new_q, vc_new_d;
   flit_t                           flit_q, flit_d;
   logic                            flit_valid_q, flit_valid_d;
   logic  [VC_NUM-1:0]              credit_q, credit_d;
   logic                            error_q, error_d;

   flit_t                           front [VC_NUM];
   logic  [VC_NUM-1:0]              rd_en;
   logic  [VC_NUM-1:0]              wr_en;
   logic                            wr_drop;
   logic  [VC_NUM-1:0]              va_req;
   logic  [VC_NUM-1:0]              sa_req;

   function automatic logic is_head(input flit_t f);
      return (f.flit_label == HEAD) || (f.flit_label == HEADTAIL);
   endfunction

   function automatic logic is_tail(input flit_t f);
      return (f.flit_label == TAIL) || (f.flit_label == HEADTAIL);
   endfunction

   // Dimension-ordered route: resolve X first, then Y; reaching both gives LOCAL
   function automatic port_t xy_route(input flit_t f);
      port_t p;
      if (int'(f.x_dest) > X_CURRENT)      p = EAST;
      else if (int'(f.x_dest) < X_CURRENT) p = WEST;
      else if (int'(f.y_dest) > Y_CURRENT) p = SOUTH;
      else if (int'(f.y_dest) < Y_CURRENT) p = NORTH;
      else                                 p = LOCAL;
      return p;
   endfunction

   // Head-of-queue flit of every VC
   always_comb begin
      for (int v = 0; v < VC_NUM; v++) begin
         front[v] = buf_q[v][rd_ptr_q[v]];
      end
   end

   // A switch grant reads only if one-hot and aimed at a non-empty ACTIVE VC
   always_comb begin
      rd_en = '0;
      if ($countones(port_if.sa_grant_i) == 1) begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (port_if.sa_grant_i[v] && state_q[v] == ACTIVE && cnt_q[v] != '0) begin
               rd_en[v] = 1'b1;
            end
         end
      end
   end

   // Accept incoming flit unless its VC is full with no same-cycle read freeing a slot
   always_comb begin
      wr_en   = '0;
      wr_drop = 1'b0;
      if (port_if.valid_flit_i) begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (int'(port_if.data_i.vc_id) == v) begin
               if (cnt_q[v] != CNT_W'(BUFFER_SIZE) || rd_en[v]) wr_en[v] = 1'b1;
               else                                              wr_drop  = 1'b1;
            end
         end
      end
   end

   // Requests are pure functions of the registered FSM state and occupancy
   always_comb begin
      va_req = '0;
      sa_req = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         va_req[v] = (state_q[v] == VA);
         sa_req[v] = (state_q[v] == ACTIVE) && (cnt_q[v] != '0);
      end
   end

   // Per-VC packet FSM, pointer/occupancy update and departure staging
   always_comb begin
      error_d      = error_q | wr_drop | ((port_if.sa_grant_i != '0) && (rd_en == '0));
      flit_d       = flit_q;
      flit_valid_d = 1'b0;
      credit_d     = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         state_d[v]    = state_q[v];
         out_port_d[v] = out_port_q[v];
         vc_new_d[v]   = vc_new_q[v];
         wr_ptr_d[v]   = wr_ptr_q[v] + PTR_W'(wr_en[v]);
         rd_ptr_d[v]   = rd_ptr_q[v] + PTR_W'(rd_en[v]);
         cnt_d[v]      = cnt_q[v] + CNT_W'(wr_en[v]) - CNT_W'(rd_en[v]);
         case (state_q[v])
            IDLE: begin
               if (cnt_q[v] != '0) begin
                  if (is_head(front[v])) begin
                     out_port_d[v] = xy_route(front[v]);
                     state_d[v]    = VA;
                  end else begin
                     error_d = 1'b1;
                  end
               end
            end
            VA: begin
               if (port_if.va_grant_i[v]) begin
                  vc_new_d[v] = port_if.vc_new_i[v];
                  state_d[v]  = ACTIVE;
               end
            end
            ACTIVE: begin
               if (rd_en[v]) begin
                  flit_d       = front[v];
                  flit_d.vc_id = vc_new_q[v];
                  flit_valid_d = 1'b1;
                  credit_d[v]  = 1'b1;
                  if (is_tail(front[v])) state_d[v] = IDLE;
               end
            end
            default: state_d[v] = IDLE;
         endcase
      end
   end

   // Control state and registered outputs; reset drops all buffered flits without credits
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         vc_new_q     <= '0;
         flit_q       <= '0;
         flit_valid_q <= 1'b0;
         credit_q     <= '0;
         error_q      <= 1'b0;
         for (int v = 0; v < VC_NUM; v++) begin
            state_q[v]    <= IDLE;
            out_port_q[v] <= LOCAL;
         end
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         vc_new_q     <= vc_new_d;
         flit_q       <= flit_d;
         flit_valid_q <= flit_valid_d;
         credit_q     <= credit_d;
         error_q      <= error_d;
         for (int v = 0; v < VC_NUM; v++) begin
            state_q[v]    <= state_d[v];
            out_port_q[v] <= out_port_d[v];
         end
      end
   end

   // Flit storage; occupancy gates every read so contents need no reset
   always_ff @(posedge clk) begin
      for (int v = 0; v < VC_NUM; v++) begin
         if (wr_en[v]) buf_q[v][wr_ptr_q[v]] <= port_if.data_i;
      end
   end

   assign port_if.credit_o     = credit_q;
   assign port_if.va_req_o     = va_req;
   assign port_if.sa_req_o     = sa_req;
   assign port_if.out_port_o   = out_port_q;
   assign port_if.flit_o       = flit_q;
   assign port_if.flit_valid_o = flit_valid_q;
   assign port_if.error_o      = error_q;

endmodule

// File: tb/tb_vc_input_port_credit.sv
// Self-checking bench for vc_input_port_credit: directed scenarios plus randomized packet traffic.
// Latency: reference model predicts registered outputs one cycle after each sampled input set.
// Backpressure: grants are issued only from the model's view of requests, with occasional illegal ones.
module tb_vc_input_port_credit;
   import vc_input_port_credit_pkg::*;

   localparam int BS = 8;
   localparam int XC = MESH_SIZE_X / 2;
   localparam int YC = MESH_SIZE_Y / 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vc_input_port_credit_if #(.VC_NUM(2)) bus ();

   vc_input_port_credit #(
      .VC_NUM(2), .BUFFER_SIZE(BS), .X_CURRENT(XC), .Y_CURRENT(YC)
   ) dut (
      .clk(clk), .rst(rst), .port_if(bus.master)
   );

   // Reference model: a FIFO of flits per VC plus the packet phase each VC is in
   // (0 = waiting for a head, 1 = awaiting VC allocation, 2 = streaming)
   flit_t                mq [2][$];
   int                   mmode [2];
   port_t                mroute [2];
   logic [VC_ID_W-1:0]   mvcn [2];
   logic [1:0]           exp_credit;
   logic                 exp_fvld;
   flit_t                exp_flit;
   logic                 exp_err;

   int   checks = 0;
   int   fails  = 0;
   bit   chk_en = 1'b0;
   int   rem [2];
   flit_label_t lbl4 [4] = '{HEAD, BODY, BODY, TAIL};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic port_t xy(input flit_t f);
      int dx = int'(f.x_dest) - XC;
      int dy = int'(f.y_dest) - YC;
      if (dx > 0) return EAST;
      if (dx < 0) return WEST;
      if (dy > 0) return SOUTH;
      if (dy < 0) return NORTH;
      return LOCAL;
   endfunction

   function automatic flit_t mkflit(input flit_label_t l, input int vc, input int x, input int y, input int pl);
      flit_t f;
      f.flit_label = l;
      f.vc_id      = VC_ID_W'(vc);
      f.x_dest     = COORD_W'(x);
      f.y_dest     = COORD_W'(y);
      f.payload    = 16'(pl);
      return f;
   endfunction

   // Advance the model by one clock using the inputs the DUT just sampled
   task automatic model_step();
      int    rdv;
      int    w;
      flit_t f;
      exp_credit = 2'b00;
      exp_fvld   = 1'b0;
      if (rst) begin
         for (int v = 0; v < 2; v++) begin
            mq[v].delete();
            mmode[v] = 0;
         end
         exp_err  = 1'b0;
         exp_flit = '0;
         return;
      end
      rdv = -1;
      if (bus.sa_grant_i == 2'b01 && mmode[0] == 2 && mq[0].size() > 0) rdv = 0;
      if (bus.sa_grant_i == 2'b10 && mmode[1] == 2 && mq[1].size() > 0) rdv = 1;
      if (bus.sa_grant_i != 2'b00 && rdv < 0) exp_err = 1'b1;
      for (int v = 0; v < 2; v++) begin
         if (mmode[v] == 0) begin
            if (mq[v].size() > 0) begin
               if (mq[v][0].flit_label inside {HEAD, HEADTAIL}) begin
                  mroute[v] = xy(mq[v][0]);
                  mmode[v]  = 1;
               end else begin
                  exp_err = 1'b1;
               end
            end
         end else if (mmode[v] == 1) begin
            if (bus.va_grant_i[v]) begin
               mvcn[v]  = bus.vc_new_i[v];
               mmode[v] = 2;
            end
         end else if (rdv == v) begin
            f = mq[v].pop_front();
            if (f.flit_label inside {TAIL, HEADTAIL}) mmode[v] = 0;
            f.vc_id       = mvcn[v];
            exp_flit      = f;
            exp_fvld      = 1'b1;
            exp_credit[v] = 1'b1;
         end
      end
      if (bus.valid_flit_i) begin
         w = int'(bus.data_i.vc_id);
         if (mq[w].size() < BS || rdv == w) mq[w].push_back(bus.data_i);
         else                               exp_err = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic idle_inputs();
      bus.valid_flit_i = 1'b0;
      bus.data_i       = '0;
      bus.va_grant_i   = '0;
      bus.vc_new_i     = '0;
      bus.sa_grant_i   = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      rst    = 1'b0;
      rem[0] = 0;
      rem[1] = 0;
   endtask

   task automatic wait_va(input int v);
      int n = 0;
      while (!bus.va_req_o[v] && n < 30) begin
         tick();
         n++;
      end
      chk("wait_va_req", 64'(bus.va_req_o[v]), 64'd1);
   endtask

   // Every cycle: DUT outputs against the model
   always @(negedge clk) begin : compare
      logic [1:0] e_va, e_sa;
      if (chk_en) begin
         for (int v = 0; v < 2; v++) begin
            e_va[v] = (mmode[v] == 1);
            e_sa[v] = (mmode[v] == 2) && (mq[v].size() > 0);
            if (mmode[v] != 0) chk($sformatf("out_port%0d", v), 64'(bus.out_port_o[v]), 64'(mroute[v]));
         end
         chk("credit_o", 64'(bus.credit_o), 64'(exp_credit));
         chk("flit_valid_o", 64'(bus.flit_valid_o), 64'(exp_fvld));
         if (exp_fvld) chk("flit_o", 64'(bus.flit_o), 64'(exp_flit));
         chk("error_o", 64'(bus.error_o), 64'(exp_err));
         chk("va_req_o", 64'(bus.va_req_o), 64'(e_va));
         chk("sa_req_o", 64'(bus.sa_req_o), 64'(e_sa));
      end
   end

   initial begin
      int          n;
      int          v;
      int          r;
      logic [1:0]  cand;
      flit_label_t lbl;

      rst = 1'b1;
      idle_inputs();
      do_reset();
      do_reset();
      chk_en = 1'b1;

      // Reset values
      chk("rst_out_port", 64'(bus.out_port_o), 64'd0);
      chk("rst_error", 64'(bus.error_o), 64'd0);
      chk("rst_reqs", 64'({bus.va_req_o, bus.sa_req_o}), 64'd0);
      chk("rst_flit_o", 64'(bus.flit_o), 64'd0);

      // Single HEADTAIL towards EAST on VC0
      bus.valid_flit_i = 1'b1;
      bus.data_i       = mkflit(HEADTAIL, 0, XC + 1, YC, 16'h1234);
      tick();
      idle_inputs();
      chk("t1_no_bypass", 64'(bus.va_req_o), 64'd0);
      tick();
      chk("t1_va_req", 64'(bus.va_req_o), 64'h1);
      chk("t1_route_east", 64'(bus.out_port_o[0]), 64'(EAST));
      bus.va_grant_i  = 2'b01;
      bus.vc_new_i[0] = 1'b1;
      tick();
      idle_inputs();
      chk("t1_sa_req", 64'(bus.sa_req_o), 64'h1);
      bus.sa_grant_i = 2'b01;
      tick();
      idle_inputs();
      chk("t1_fvld", 64'(bus.flit_valid_o), 64'd1);
      chk("t1_vc_id", 64'(bus.flit_o.vc_id), 64'd1);
      chk("t1_payload", 64'(bus.flit_o.payload), 64'h1234);
      chk("t1_credit", 64'(bus.credit_o), 64'h1);
      tick();
      chk("t1_back_idle", 64'({bus.va_req_o, bus.sa_req_o, bus.credit_o}), 64'd0);

      // Four-flit packet on VC1, allocator grants whenever requested
      n = 0;
      for (int c = 0; c < 20; c++) begin
         idle_inputs();
         if (c < 4) begin
            bus.valid_flit_i = 1'b1;
            bus.data_i       = mkflit(lbl4[c], 1, 0, YC, 16'h100 + c);
         end
         bus.va_grant_i[1] = bus.va_req_o[1];
         if (bus.sa_req_o[1]) bus.sa_grant_i = 2'b10;
         tick();
         if (bus.flit_valid_o && bus.credit_o == 2'b10) n++;
      end
      idle_inputs();
      chk("t2_departures", 64'(n), 64'd4);
      chk("t2_idle_empty", 64'({bus.va_req_o, bus.sa_req_o}), 64'd0);

      // Fill VC0, overflow, then a read and write together on the full VC
      do_reset();
      for (int i = 0; i < 8; i++) begin
         bus.valid_flit_i = 1'b1;
         bus.data_i       = mkflit((i == 0) ? HEAD : BODY, 0, XC, YC, i);
         tick();
      end
      idle_inputs();
      tick();
      chk("t3_full_no_err", 64'(bus.error_o), 64'd0);
      bus.valid_flit_i = 1'b1;
      bus.data_i       = mkflit(BODY, 0, XC, YC, 16'h99);
      tick();
      idle_inputs();
      chk("t3_overflow_err", 64'(bus.error_o), 64'd1);
      wait_va(0);
      chk("t3_route_local", 64'(bus.out_port_o[0]), 64'(LOCAL));
      bus.va_grant_i  = 2'b01;
      bus.vc_new_i[0] = 1'b1;
      tick();
      idle_inputs();
      bus.valid_flit_i = 1'b1;
      bus.data_i       = mkflit(BODY, 0, XC, YC, 16'hA);
      bus.sa_grant_i   = 2'b01;
      tick();
      idle_inputs();
      chk("t3_rw_fvld", 64'(bus.flit_valid_o), 64'd1);
      chk("t3_rw_credit", 64'(bus.credit_o), 64'h1);
      n = 0;
      for (int c = 0; c < 20 && bus.sa_req_o[0]; c++) begin
         bus.sa_grant_i = 2'b01;
         tick();
         idle_inputs();
         if (bus.flit_valid_o) n++;
      end
      chk("t3_drain_count", 64'(n), 64'd8);
      bus.valid_flit_i = 1'b1;
      bus.data_i       = mkflit(TAIL, 0, XC, YC, 16'hF);
      tick();
      idle_inputs();
      tick();
      bus.sa_grant_i = 2'b01;
      tick();
      idle_inputs();
      tick();
      chk("t3_idle_after_tail", 64'({bus.va_req_o, bus.sa_req_o}), 64'd0);

      // Illegal grants and a BODY flit arriving at an idle VC
      do_reset();
      bus.sa_grant_i = 2'b11;
      tick();
      idle_inputs();
      chk("t5_multi_fvld", 64'(bus.flit_valid_o), 64'd0);
      chk("t5_multi_err", 64'(bus.error_o), 64'd1);
      do_reset();
      chk("t5_err_cleared", 64'(bus.error_o), 64'd0);
      bus.sa_grant_i = 2'b01;
      tick();
      idle_inputs();
      chk("t5_idle_gnt_fvld", 64'(bus.flit_valid_o), 64'd0);
      chk("t5_idle_gnt_err", 64'(bus.error_o), 64'd1);
      do_reset();
      bus.valid_flit_i = 1'b1;
      bus.data_i       = mkflit(BODY, 1, XC, YC, 16'h5);
      tick();
      idle_inputs();
      chk("t5_body_err_early", 64'(bus.error_o), 64'd0);
      tick();
      chk("t5_body_err", 64'(bus.error_o), 64'd1);

      // Reset while VC0 streams with three flits still buffered
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus.valid_flit_i = 1'b1;
         bus.data_i       = mkflit((i == 0) ? HEAD : BODY, 0, XC - 1, YC, 16'h200 + i);
         tick();
      end
      idle_inputs();
      wait_va(0);
      chk("t6_route_west", 64'(bus.out_port_o[0]), 64'(WEST));
      bus.va_grant_i = 2'b01;
      tick();
      idle_inputs();
      bus.sa_grant_i = 2'b01;
      tick();
      idle_inputs();
      chk("t6_first_read", 64'(bus.flit_valid_o), 64'd1);
      rst            = 1'b1;
      bus.sa_grant_i = 2'b01;
      tick();
      rst = 1'b0;
      idle_inputs();
      chk("t6_rst_credit", 64'(bus.credit_o), 64'd0);
      chk("t6_rst_fvld", 64'(bus.flit_valid_o), 64'd0);
      chk("t6_rst_flit", 64'(bus.flit_o), 64'd0);
      chk("t6_rst_port", 64'(bus.out_port_o), 64'd0);
      tick();
      tick();
      chk("t6_buffer_empty", 64'({bus.va_req_o, bus.sa_req_o, bus.credit_o}), 64'd0);

      // Randomized interleaved traffic on both VCs
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         idle_inputs();
         if ($urandom_range(0, 599) == 0) begin
            rst    = 1'b1;
            rem[0] = 0;
            rem[1] = 0;
         end else begin
            rst = 1'b0;
            v   = $urandom_range(0, 1);
            if ($urandom_range(0, 99) < 55 && mq[v].size() < BS) begin
               if (rem[v] == 0) begin
                  rem[v] = $urandom_range(1, 4);
                  lbl    = (rem[v] == 1) ? HEADTAIL : HEAD;
               end else begin
                  lbl    = (rem[v] == 1) ? TAIL : BODY;
               end
               rem[v]--;
               bus.valid_flit_i = 1'b1;
               bus.data_i = mkflit(lbl, v, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            end
            for (int k = 0; k < 2; k++) begin
               bus.va_grant_i[k] = 1'($urandom_range(0, 1));
               bus.vc_new_i[k]   = VC_ID_W'($urandom_range(0, 1));
            end
            for (int k = 0; k < 2; k++) cand[k] = (mmode[k] == 2) && (mq[k].size() > 0);
            r = $urandom_range(0, 299);
            if (r == 0)      bus.sa_grant_i = 2'b11;
            else if (r == 1) bus.sa_grant_i = 2'b01;
            else if (r < 220 && cand != 2'b00) begin
               if (cand == 2'b11) bus.sa_grant_i = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
               else               bus.sa_grant_i = cand;
            end
         end
         tick();
      end
      rst = 1'b0;
      idle_inputs();
      tick();
      @(negedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
      $finish;
   end

endmodule

// File: doc/vc_input_port_credit.md
Name: vc_input_port_credit

Overview:
Next-generation router input port with parametrised VC count and per-VC depth. Each VC holds a circular flit buffer and a per-VC packet state machine (IDLE/VA/ACTIVE). Flow control to the upstream router is credit-based, one credit pulse per flit read, replacing on/off. The port sits between the link receiver and the VC/switch allocators and crossbar; it does XY route computation on head flits and rewrites vc_id on departure.

Parameters:
VC_NUM, 2, number of virtual channels; power of two, at least 2
BUFFER_SIZE, 8, flit slots per VC; power of two, at least 2
X_CURRENT, MESH_SIZE_X/2, router X coordinate
Y_CURRENT, MESH_SIZE_Y/2, router Y coordinate

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
data_i  in  flit_t  incoming flit; the vc_id field selects the target VC
valid_flit_i  in  1  data_i valid this cycle
credit_o  out  VC_NUM  one-cycle pulse per VC when a slot is freed
va_req_o  out  VC_NUM  VC requests downstream VC allocation
out_port_o  out  VC_NUM x port_t  latched route per VC
va_grant_i  in  VC_NUM  VC allocation granted, one cycle
vc_new_i  in  VC_NUM x VC_SIZE  downstream VC id, sampled with va_grant_i
sa_req_o  out  VC_NUM  VC requests the switch
sa_grant_i  in  VC_NUM  one-hot switch grant
flit_o  out  flit_t  departing flit toward the crossbar
flit_valid_o  out  1  flit_o valid
error_o  out  1  sticky protocol error

Behaviour:
- Reset (synchronous, active-high), required values:
  - all buffers empty, read/write pointers 0, all FSMs IDLE
  - credit_o, va_req_o, sa_req_o, flit_valid_o, error_o = 0
  - out_port_o = LOCAL, flit_o = 0
  - rst asserted mid-packet discards all contents and gives no credit return.
- Write:
  - When valid_flit_i=1, data_i is stored at the write pointer of VC data_i.vc_id; the pointer wraps at BUFFER_SIZE.
  - Occupancy counter is log2(BUFFER_SIZE)+1 bits.
  - Write to a full VC: flit dropped, error_o set.
- Per-VC FSM:
  - IDLE: if the buffer is non-empty and the front flit is HEAD or HEADTAIL, compute XY route from its x_dest/y_dest (X first; equal coordinates give LOCAL), latch it into out_port_o, go to VA. A non-head flit at the front in IDLE sets error_o and stays IDLE.
  - VA: va_req_o=1. On va_grant_i, latch vc_new_i and go to ACTIVE.
  - ACTIVE: sa_req_o = buffer non-empty. On sa_grant_i, read the front flit. If that flit is TAIL or HEADTAIL, go to IDLE next cycle.
- Read / departure:
  - On grant, read the front flit and advance the read pointer.
  - Next cycle: flit_o = that flit with vc_id replaced by the latched vc_new, flit_valid_o=1, credit_o[vc]=1 for one cycle. Latency is 1 cycle from grant.
  - A grant that is not one-hot, or targets a VC not in ACTIVE or empty, is ignored and sets error_o.
- Simultaneous read and write on the same VC, including full: both occur and occupancy is unchanged. Write to a full VC with a same-cycle read is accepted.
- Empty VC written in cycle N is first visible to the FSM in cycle N+1. No same-cycle bypass.
- A new head queued behind a tail waits until the FSM returns to IDLE. No VA request is issued while ACTIVE.
- error_o clears only on rst.

Test Plan:
- Reset, then HEADTAIL on VC0 with dest (X_CURRENT+1, Y_CURRENT) -> VC0 IDLE->VA in 1 cycle, out_port_o[0]=EAST, va_req_o[0]=1. va_grant_i with vc_new=1 -> sa_req_o[0]=1. sa_grant_i=01 -> next cycle flit_valid_o=1, flit_o.vc_id=1, credit_o=01, VC0 back to IDLE.
- 4-flit packet (HEAD,BODY,BODY,TAIL) on VC1 with grants every cycle -> 4 consecutive flit_valid_o, 4 credit_o[1] pulses, VC1 ends IDLE with the buffer empty.
- Fill VC0 with 8 flits and no grants, then a 9th write -> error_o=1, occupancy stays 8. Then a same-cycle read and write on the full VC -> accepted, occupancy stays 8, no error change.
- Interleaved VC0/VC1 writes, grants alternating 01/10 -> output order follows grant order, vc_id rewritten per VC, pointers wrap correctly after 20 flits.
- Illegal grants: sa_grant_i=11, and a grant to an IDLE VC -> no flit_valid_o, error_o=1. BODY flit arriving first on an idle VC -> error_o=1.
- rst asserted while VC0 is ACTIVE with 3 flits buffered -> next cycle all outputs at reset values, no credit pulses, buffer empty.
